// File: rtl/answer_sequencer.sv
// answer_sequencer: note-sequence store and playback engine.
// Holds DEPTH notes of NOTE_W bits, written per slot or in bulk, and replays
// the first `len` notes, each held for TICKS_PER_STEP cycles, with optional
// looping, abort, and a one-cycle completion pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset (also clears note memory)
//   wr_en      write wr_data into slot wr_addr (out-of-range addresses ignored)
//   wr_addr    slot index
//   wr_data    note value
//   load_en    bulk load of every slot from load_data; wins over wr_en
//   load_data  packed notes, slot 0 in the LSBs
//   len        notes to play, sampled at start, clamped to DEPTH
//   play       start request, acted on in IDLE only
//   stop       abort playback; also blocks a same-cycle play
//   loop       sampled at the last-note boundary: wrap to slot 0 when high
//   note_out   current note, REST_NOTE when idle
//   note_valid high while a note is being played
//   step_idx   index of the current note, 0 when idle
//   busy       high while playing
//   done       one-cycle pulse on normal completion
module answer_sequencer #(
    parameter int unsigned NOTE_W         = 4,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TICKS_PER_STEP = 5000000,
    parameter int unsigned REST_NOTE      = 0,
    localparam int unsigned AW            = $clog2(DEPTH),
    localparam int unsigned LW            = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [NOTE_W-1:0]       wr_data,
    input  logic                    load_en,
    input  logic [DEPTH*NOTE_W-1:0] load_data,
    input  logic [LW-1:0]           len,
    input  logic                    play,
    input  logic                    stop,
    input  logic                    loop,
    output logic [NOTE_W-1:0]       note_out,
    output logic                    note_valid,
    output logic [AW-1:0]           step_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CW = $clog2(TICKS_PER_STEP);

    typedef enum logic {
        IDLE,
        PLAY
    } state_e;

    state_e              state_q;
    logic [NOTE_W-1:0]   mem_q [DEPTH];
    logic [CW-1:0]       cnt_q;
    logic [LW-1:0]       len_q;
    logic [AW-1:0]       step_idx_q;
    logic [NOTE_W-1:0]   note_q;
    logic                note_valid_q;
    logic                busy_q;
    logic                done_q;

    logic [LW-1:0]       len_clamped_c;
    logic                step_end_c;
    logic                last_step_c;

    // Requested length limited to the number of slots.
    assign len_clamped_c = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

    // Final cycle of the current note's hold time.
    assign step_end_c    = (cnt_q == CW'(TICKS_PER_STEP - 1));

    // Current note is the last one of the latched length.
    assign last_step_c   = (LW'(step_idx_q) == (len_q - LW'(1)));

    // Note memory: bulk load has priority; per-slot decode drops addresses >= DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_en) begin
                    mem_q[i] <= load_data[i*NOTE_W +: NOTE_W];
                end else if (wr_en && (wr_addr == AW'(i))) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    // Playback FSM with registered outputs; the note is captured on entry so
    // later writes to the playing slot only show on its next entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            step_idx_q   <= '0;
            note_q       <= NOTE_W'(REST_NOTE);
            note_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (play && !stop && (len_clamped_c != '0)) begin
                        state_q      <= PLAY;
                        len_q        <= len_clamped_c;
                        cnt_q        <= '0;
                        step_idx_q   <= '0;
                        note_q       <= mem_q[0];
                        note_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        step_idx_q   <= '0;
                        note_q       <= NOTE_W'(REST_NOTE);
                        note_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (step_end_c) begin
                        cnt_q <= '0;
                        if (!last_step_c) begin
                            step_idx_q <= step_idx_q + AW'(1);
                            note_q     <= mem_q[step_idx_q + AW'(1)];
                        end else if (loop) begin
                            step_idx_q <= '0;
                            note_q     <= mem_q[0];
                        end else begin
                            state_q      <= IDLE;
                            step_idx_q   <= '0;
                            note_q       <= NOTE_W'(REST_NOTE);
                            note_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign note_out   = note_q;
    assign note_valid = note_valid_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_answer_sequencer.sv
// Directed testbench for answer_sequencer (DEPTH=8, NOTE_W=4, TICKS_PER_STEP=4).
module tb_answer_sequencer;

    localparam int unsigned NOTE_W = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TPS    = 4;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LW     = $clog2(DEPTH + 1);

    logic                    clk;
    logic                    reset;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [NOTE_W-1:0]       wr_data;
    logic                    load_en;
    logic [DEPTH*NOTE_W-1:0] load_data;
    logic [LW-1:0]           len;
    logic                    play;
    logic                    stop;
    logic                    loop;
    logic [NOTE_W-1:0]       note_out;
    logic                    note_valid;
    logic [AW-1:0]           step_idx;
    logic                    busy;
    logic                    done;

    int n_pass;
    int n_total;

    answer_sequencer #(
        .NOTE_W        (NOTE_W),
        .DEPTH         (DEPTH),
        .TICKS_PER_STEP(TPS),
        .REST_NOTE     (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load_en   (load_en),
        .load_data (load_data),
        .len       (len),
        .play      (play),
        .stop      (stop),
        .loop      (loop),
        .note_out  (note_out),
        .note_valid(note_valid),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full note: TPS cycles of the given value at the given index.
    task automatic expect_note(input string tag, input logic [3:0] nv, input int idx);
        for (int k = 0; k < TPS; k++) begin
            check({tag, " note"},  32'(note_out),   32'(nv));
            check({tag, " valid"}, 32'(note_valid), 32'd1);
            check({tag, " busy"},  32'(busy),       32'd1);
            check({tag, " step"},  32'(step_idx),   32'(idx));
            check({tag, " done"},  32'(done),       32'd0);
            tick();
        end
    endtask

    // Observed right after the finishing edge: single done pulse, idle outputs.
    task automatic expect_finish(input string tag);
        check({tag, " done"},  32'(done),       32'd1);
        check({tag, " valid"}, 32'(note_valid), 32'd0);
        check({tag, " busy"},  32'(busy),       32'd0);
        check({tag, " note"},  32'(note_out),   32'd0);
        check({tag, " step"},  32'(step_idx),   32'd0);
        tick();
        check({tag, " done1"}, 32'(done),       32'd0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " done"},  32'(done),       32'd0);
        check({tag, " valid"}, 32'(note_valid), 32'd0);
        check({tag, " busy"},  32'(busy),       32'd0);
        check({tag, " note"},  32'(note_out),   32'd0);
        check({tag, " step"},  32'(step_idx),   32'd0);
    endtask

    task automatic start_play(input int l);
        len  = LW'(l);
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    initial begin
        logic [3:0] seq1 [8];
        logic [3:0] seq3 [8];
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        load_en   = 1'b0;
        load_data = '0;
        len       = '0;
        play      = 1'b0;
        stop      = 1'b0;
        loop      = 1'b0;
        seq1 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        seq3 = '{4'hF, 4'h2, 4'h3, 4'hA, 4'h5, 4'h6, 4'h7, 4'h8};

        repeat (3) tick();
        expect_idle("reset");
        reset = 1'b0;
        tick();

        // Bulk load and full non-loop playback.
        load_en   = 1'b1;
        load_data = 32'h8765_4321;
        tick();
        load_en = 1'b0;
        start_play(8);
        for (int i = 0; i < 8; i++) expect_note("bulk", seq1[i], i);
        expect_finish("bulk_end");

        // Per-slot writes, looped play, loop released during second pass.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA; tick();
        wr_addr = 3'd0; wr_data = 4'hF; tick();
        wr_en = 1'b0;
        loop = 1'b1;
        start_play(4);
        for (int i = 0; i < 4; i++) expect_note("loop_p1", seq3[i], i);
        expect_note("loop_p2", 4'hF, 0);
        expect_note("loop_p2", 4'h2, 1);
        loop = 1'b0;
        expect_note("loop_p2", 4'h3, 2);
        expect_note("loop_p2", 4'hA, 3);
        expect_finish("loop_end");

        // len=0 is ignored.
        len  = '0;
        play = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_idle("len0");
        end
        play = 1'b0;

        // len=12 clamps to 8.
        start_play(12);
        for (int i = 0; i < 8; i++) expect_note("clamp", seq3[i], i);
        expect_finish("clamp_end");

        // Stop in the 2nd cycle of note 5.
        start_play(8);
        for (int i = 0; i < 4; i++) expect_note("stop", seq3[i], i);
        check("stop n5 c1", 32'(note_out), 32'h5);
        tick();
        check("stop n5 c2", 32'(note_out), 32'h5);
        stop = 1'b1;
        tick();
        expect_idle("stopped");
        // stop and play together in IDLE: stop wins.
        play = 1'b1;
        tick();
        expect_idle("stop_play");
        stop = 1'b0;
        tick();
        play = 1'b0;
        check("restart busy", 32'(busy),     32'd1);
        check("restart note", 32'(note_out), 32'hF);
        check("restart step", 32'(step_idx), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_idle("restart_stop");

        // Write to the slot currently playing: old value held, new on next pass.
        loop = 1'b1;
        start_play(4);
        expect_note("live", 4'hF, 0);
        expect_note("live", 4'h2, 1);
        check("live s2 c1", 32'(note_out), 32'h3);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hC;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < TPS - 1; k++) begin
            check("live s2 held", 32'(note_out), 32'h3);
            tick();
        end
        expect_note("live", 4'hA, 3);
        expect_note("live_p2", 4'hF, 0);
        expect_note("live_p2", 4'h2, 1);
        expect_note("live_p2", 4'hC, 2);
        stop = 1'b1;
        loop = 1'b0;
        tick();
        stop = 1'b0;
        expect_idle("live_stop");

        // load_en and wr_en together: bulk data wins.
        load_en = 1'b1; load_data = 32'h0FED_CBA9;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h5;
        tick();
        load_en = 1'b0; wr_en = 1'b0;
        start_play(2);
        expect_note("prio", 4'h9, 0);
        expect_note("prio", 4'hA, 1);
        expect_finish("prio_end");

        // Reset mid note 3 clears outputs and memory.
        load_en = 1'b1; load_data = 32'h8765_4321;
        tick();
        load_en = 1'b0;
        start_play(8);
        expect_note("rst", 4'h1, 0);
        expect_note("rst", 4'h2, 1);
        check("rst n3", 32'(note_out), 32'h3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_idle("rst_now");
        start_play(3);
        for (int i = 0; i < 3; i++) expect_note("rst_mem", 4'h0, i);
        expect_finish("rst_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
